page_stream_bridge: RTL and testbench
=====================================

// Module: page_stream_bridge
// PURPOSE
//  Parametrised multi-channel buffer between a page's leaf_interface and its user kernel.
//  Input path (interface->kernel) and output path (kernel->interface) each have one FIFO per channel.
//  Decouples the two vld/ack handshakes.
//  Adds a pause/drain controller so a page can be quiesced before partial reconfiguration.
// PARAMETERS
//  PAYLOAD_BITS   32  data word width per channel
//  NUM_IN_PORTS   1   interface->kernel channels (1..7)
//  NUM_OUT_PORTS  1   kernel->interface channels (1..7)
//  FIFO_DEPTH     4   entries per channel FIFO; power of two, >=2
// PORTS
//  clk          in   1                        page clock
//  reset        in   1                        asynchronous, active-high reset
//  pause_req    in   1                        level; request quiesce
//  paused       out  1                        high while in HALT
//  in_data_i    in   NUM_IN_PORTS*PAYLOAD_BITS  from leaf_interface; channel k at [k*PB +: PB]
//  in_vld_i     in   NUM_IN_PORTS             from leaf_interface
//  in_ack_o     out  NUM_IN_PORTS             to leaf_interface
//  in_data_o    out  NUM_IN_PORTS*PAYLOAD_BITS  to kernel Input_k_V_V
//  in_vld_o     out  NUM_IN_PORTS             to kernel _ap_vld
//  in_ack_i     in   NUM_IN_PORTS             from kernel _ap_ack
//  out_data_i   in   NUM_OUT_PORTS*PAYLOAD_BITS from kernel Output_k_V_V
//  out_vld_i    in   NUM_OUT_PORTS            from kernel _ap_vld
//  out_ack_o    out  NUM_OUT_PORTS            to kernel _ap_ack
//  out_data_o   out  NUM_OUT_PORTS*PAYLOAD_BITS to leaf_interface
//  out_vld_o    out  NUM_OUT_PORTS            to leaf_interface
//  out_ack_i    in   NUM_OUT_PORTS            from leaf_interface
// BEHAVIOUR
//  - Handshake on every side: a word transfers in a cycle where vld & ack are both high.
//  - ack_o = FIFO not full (and accepting, see FSM). It is combinational from FIFO state only, never from vld.
//  - vld_o = FIFO not empty. data_o = FIFO head, driven directly from registers.
//  - vld_o and data_o stay stable until the word is acked.
//  - Latency: a word written in cycle t is visible on the far side at t+1. Sustained throughput is 1 word/cycle/channel.
//  - Full FIFO: simultaneous push and pop is allowed; ack_o is low while full, even when a pop happens in that cycle.
//  - Empty FIFO: no bypass path.
//  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty are decided by the MSB compare.
//  - FSM:
//    - RUN: all paths flow. pause_req=1 -> DRAIN.
//    - DRAIN: in_ack_o forced 0, so nothing new enters from the interface. Input FIFOs keep delivering to the kernel. The output path flows normally.
//      All FIFOs empty -> HALT. pause_req=0 -> RUN.
//    - HALT: paused=1, in_ack_o=0, out_ack_o=0. pause_req=0 -> RUN on the next cycle.
//  - Reset (any time, including mid-transfer):
//    - FIFOs empty, FSM=RUN, paused=0.
//    - All vld_o=0. All ack_o=1, since the FIFOs are empty.
//    - data_o=0.
//    - Words in flight are dropped; the leaf_interface resend mechanism recovers them.
// CONFIGURATION
//  PAGE_BRIDGE_STATS_EN defined:
//    - Extra output stat_words, width (NUM_IN_PORTS+NUM_OUT_PORTS)*32.
//    - One saturating 32-bit transfer counter per channel: input channels first, then output channels.
//    - Each counter increments on the interface-side handshake: in_vld_i&in_ack_o, or out_vld_o&out_ack_i.
//    - Counters are cleared by reset. They saturate at 0xFFFFFFFF.
//  Not defined: no port and no counter logic. All other behaviour is identical.
// STRUCTURE
//  Package page_bridge_pkg: FSM state enum {RUN, DRAIN, HALT}, plus the function clog2 used for the pointer width.
//  Sub-module page_bridge_fifo: one-clock FIFO with ports clk, reset, wr_vld, wr_ack, wr_data, rd_vld, rd_ack, rd_data.
//  The top instantiates one page_bridge_fifo per channel in a generate loop. The FSM and optional counters live in the top.
// TESTING
//  1. Reset with NUM_IN=NUM_OUT=2, DEPTH=4.
//     -> All vld_o=0, all ack_o=1, paused=0. The same values hold one cycle after reset deasserts.
//  2. Kernel holds in_ack_i=0 while 5 words 0xA0..0xA4 are driven on channel 0.
//     -> 4 words accepted; in_ack_o[0]=0 from the cycle after the 4th.
//     -> After release, words are delivered in order 0xA0..0xA3.
//  3. Continuous streaming on all channels with both acks held high.
//     -> 1 word/cycle per channel, first word out at t+1, no reordering across 100 words.
//  4. 3 words queued in input FIFO 0 when pause_req=1.
//     -> in_ack_o drops the next cycle. The 3 words still reach the kernel.
//     -> paused=1 one cycle after all FIFOs are empty.
//     -> Drop pause_req -> RUN, acks return.
//  5. Reset asserted mid-burst with FIFOs half full.
//     -> Immediate async clear: vld_o=0, stat counters 0. No stale word appears after reset.
//  6. With STATS_EN: push 0x10 words on input channel 1.
//     -> That counter reads 16. Force the counter to 0xFFFFFFFE, then send 3 words -> it reads 0xFFFFFFFF.

Source files
------------

// File: rtl/page_bridge_pkg.sv
// Shared types and helpers for the page stream bridge.
package page_bridge_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } bridge_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/page_bridge_fifo.sv
// Single-clock FIFO with registered head; pointers carry one extra wrap bit.
module page_bridge_fifo
  import page_bridge_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  output logic             wr_ack,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_vld,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // Ack depends only on occupancy, so a pop in a full cycle does not raise it.
  assign wr_ack  = ~w_full;
  assign rd_vld  = ~w_empty;
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  assign w_push = wr_vld & ~w_full;
  assign w_pop  = rd_ack & ~w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/page_stream_bridge.sv
// Per-channel FIFO bridge between leaf interface and kernel with pause/drain control.
// Optional per-channel saturating transfer counters when PAGE_BRIDGE_STATS_EN is defined.
module page_stream_bridge
  import page_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 1,
  parameter int NUM_OUT_PORTS = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  pause_req,
  output logic                                  paused,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_data_i,
  input  logic [NUM_IN_PORTS-1:0]               in_vld_i,
  output logic [NUM_IN_PORTS-1:0]               in_ack_o,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_data_o,
  output logic [NUM_IN_PORTS-1:0]               in_vld_o,
  input  logic [NUM_IN_PORTS-1:0]               in_ack_i,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_data_i,
  input  logic [NUM_OUT_PORTS-1:0]              out_vld_i,
  output logic [NUM_OUT_PORTS-1:0]              out_ack_o,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_data_o,
  output logic [NUM_OUT_PORTS-1:0]              out_vld_o,
  input  logic [NUM_OUT_PORTS-1:0]              out_ack_i
`ifdef PAGE_BRIDGE_STATS_EN
  ,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*32-1:0] stat_words
`endif
);

  bridge_state_t r_state;
  bridge_state_t w_state_nxt;

  logic [NUM_IN_PORTS-1:0]  w_in_fifo_ack;
  logic [NUM_OUT_PORTS-1:0] w_out_fifo_ack;
  logic                     w_in_open;
  logic                     w_out_open;
  logic                     w_all_empty;

  assign w_in_open   = (r_state == ST_RUN);
  assign w_out_open  = (r_state != ST_HALT);
  assign w_all_empty = ~(|in_vld_o) & ~(|out_vld_o);
  assign paused      = (r_state == ST_HALT);

  assign in_ack_o  = w_in_fifo_ack & {NUM_IN_PORTS{w_in_open}};
  assign out_ack_o = w_out_fifo_ack & {NUM_OUT_PORTS{w_out_open}};

  genvar g;
  generate
    for (g = 0; g < NUM_IN_PORTS; g++) begin : g_in
      page_bridge_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_vld  (in_vld_i[g] & w_in_open),
        .wr_ack  (w_in_fifo_ack[g]),
        .wr_data (in_data_i[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
        .rd_vld  (in_vld_o[g]),
        .rd_ack  (in_ack_i[g]),
        .rd_data (in_data_o[g*PAYLOAD_BITS +: PAYLOAD_BITS])
      );
    end
    for (g = 0; g < NUM_OUT_PORTS; g++) begin : g_out
      page_bridge_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_vld  (out_vld_i[g] & w_out_open),
        .wr_ack  (w_out_fifo_ack[g]),
        .wr_data (out_data_i[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
        .rd_vld  (out_vld_o[g]),
        .rd_ack  (out_ack_i[g]),
        .rd_data (out_data_o[g*PAYLOAD_BITS +: PAYLOAD_BITS])
      );
    end
  endgenerate

  // Releasing pause_req wins over reaching empty while draining.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (pause_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!pause_req)      w_state_nxt = ST_RUN;
        else if (w_all_empty) w_state_nxt = ST_HALT;
      end
      ST_HALT:  if (!pause_req) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

`ifdef PAGE_BRIDGE_STATS_EN
  localparam int NCH = NUM_IN_PORTS + NUM_OUT_PORTS;

  logic [NCH-1:0] w_xfer;
  logic [31:0]    r_stat [NCH];

  assign w_xfer = {out_vld_o & out_ack_i, in_vld_i & in_ack_o};

  generate
    for (g = 0; g < NCH; g++) begin : g_stat
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 r_stat[g] <= '0;
        else if (w_xfer[g] && (r_stat[g] != '1))   r_stat[g] <= r_stat[g] + 32'd1;
      end
      assign stat_words[g*32 +: 32] = r_stat[g];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_page_stream_bridge.sv
// Directed bench for page_stream_bridge with two channels per direction, depth 4.
module tb_page_stream_bridge;

  localparam int PB = 32;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int DP = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pause_req = 1'b0;
  logic             paused;
  logic [NI*PB-1:0] in_data_i = '0;
  logic [NI-1:0]    in_vld_i = '0;
  logic [NI-1:0]    in_ack_o;
  logic [NI*PB-1:0] in_data_o;
  logic [NI-1:0]    in_vld_o;
  logic [NI-1:0]    in_ack_i = '0;
  logic [NO*PB-1:0] out_data_i = '0;
  logic [NO-1:0]    out_vld_i = '0;
  logic [NO-1:0]    out_ack_o;
  logic [NO*PB-1:0] out_data_o;
  logic [NO-1:0]    out_vld_o;
  logic [NO-1:0]    out_ack_i = '0;
`ifdef PAGE_BRIDGE_STATS_EN
  logic [(NI+NO)*32-1:0] stat_words;
`endif

  int n_cmp = 0;
  int n_err = 0;

  page_stream_bridge #(
    .PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .FIFO_DEPTH(DP)
  ) dut (
    .clk(clk), .reset(reset), .pause_req(pause_req), .paused(paused),
    .in_data_i(in_data_i), .in_vld_i(in_vld_i), .in_ack_o(in_ack_o),
    .in_data_o(in_data_o), .in_vld_o(in_vld_o), .in_ack_i(in_ack_i),
    .out_data_i(out_data_i), .out_vld_i(out_vld_i), .out_ack_o(out_ack_o),
    .out_data_o(out_data_o), .out_vld_o(out_vld_o), .out_ack_i(out_ack_i)
`ifdef PAGE_BRIDGE_STATS_EN
    , .stat_words(stat_words)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_in_vld"},  64'(in_vld_o),  64'h0);
    check_val({tag, "_out_vld"}, 64'(out_vld_o), 64'h0);
    check_val({tag, "_in_ack"},  64'(in_ack_o),  64'h3);
    check_val({tag, "_out_ack"}, 64'(out_ack_o), 64'h3);
    check_val({tag, "_paused"},  64'(paused),    64'h0);
  endtask

  int sent, got;
  int snd [4];
  int rcv [4];

  initial begin
    // Reset state, during and after reset
    #3;
    check_idle("rst");
    check_val("rst_in_data",  in_data_o,  64'h0);
    check_val("rst_out_data", out_data_o, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_rst");

    // Fill input FIFO 0 while the kernel stalls
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      if (c >= 4) check_val("full_ack", 64'(in_ack_o[0]), 64'h0);
      in_vld_i[0] = 1'b1;
      in_data_i[0 +: PB] = 32'hA0 + sent;
      if (in_ack_o[0]) sent++;
      @(negedge clk);
    end
    check_val("fill_count", 64'(sent), 64'd4);
    in_vld_i[0] = 1'b0;
    in_ack_i[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      if (in_vld_o[0]) begin
        check_val("fill_order", 64'(in_data_o[0 +: PB]), 64'(32'hA0 + got));
        got++;
      end
      @(negedge clk);
    end
    check_val("fill_delivered", 64'(got), 64'd4);
    check_val("fill_empty", 64'(in_vld_o[0]), 64'h0);

    // Continuous streaming, all channels
    in_ack_i  = '1;
    out_ack_i = '1;
    for (int i = 0; i < 4; i++) begin snd[i] = 0; rcv[i] = 0; end
    for (int c = 0; c < 101; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (in_vld_o[k]) begin
          check_val("stream_in", 64'(in_data_o[k*PB +: PB]), 64'(32'h1000_0000 + k*65536 + rcv[k]));
          rcv[k]++;
        end
        if (out_vld_o[k]) begin
          check_val("stream_out", 64'(out_data_o[k*PB +: PB]), 64'(32'h2000_0000 + k*65536 + rcv[k+2]));
          rcv[k+2]++;
        end
        if (snd[k] < 100) begin
          in_vld_i[k] = 1'b1;
          in_data_i[k*PB +: PB] = 32'h1000_0000 + k*65536 + snd[k];
          if (in_ack_o[k]) snd[k]++;
        end else in_vld_i[k] = 1'b0;
        if (snd[k+2] < 100) begin
          out_vld_i[k] = 1'b1;
          out_data_i[k*PB +: PB] = 32'h2000_0000 + k*65536 + snd[k+2];
          if (out_ack_o[k]) snd[k+2]++;
        end else out_vld_i[k] = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) check_val("stream_rate", 64'(rcv[i]), 64'd100);
    in_vld_i  = '0;
    out_vld_i = '0;
    @(negedge clk);

    // Pause with three words queued in input FIFO 0
    in_ack_i = '0;
    for (int i = 0; i < 3; i++) begin
      in_vld_i[0] = 1'b1;
      in_data_i[0 +: PB] = 32'hB0 + i;
      @(negedge clk);
    end
    in_vld_i[0] = 1'b0;
    pause_req = 1'b1;
    check_val("pause_ack_run", 64'(in_ack_o), 64'h3);
    @(negedge clk);
    check_val("drain_in_ack",  64'(in_ack_o),  64'h0);
    check_val("drain_out_ack", 64'(out_ack_o), 64'h3);
    check_val("drain_paused",  64'(paused),    64'h0);
    in_ack_i[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (!in_vld_o[0]) break;
      check_val("drain_order", 64'(in_data_o[0 +: PB]), 64'(32'hB0 + got));
      got++;
      @(negedge clk);
    end
    check_val("drain_count", 64'(got), 64'd3);
    check_val("drain_not_yet_paused", 64'(paused), 64'h0);
    @(negedge clk);
    check_val("halt_paused",  64'(paused),    64'h1);
    check_val("halt_in_ack",  64'(in_ack_o),  64'h0);
    check_val("halt_out_ack", 64'(out_ack_o), 64'h0);
    pause_req = 1'b0;
    @(negedge clk);
    check_idle("resume");

    // Asynchronous reset mid-burst
    in_ack_i  = '0;
    out_ack_i = '0;
    for (int i = 0; i < 2; i++) begin
      in_vld_i[0]  = 1'b1;
      in_data_i[0 +: PB] = 32'hC0 + i;
      out_vld_i[1] = 1'b1;
      out_data_i[PB +: PB] = 32'hD0 + i;
      @(negedge clk);
    end
    in_vld_i  = '0;
    out_vld_i = '0;
    check_val("pre_rst_in_vld",  64'(in_vld_o[0]),  64'h1);
    check_val("pre_rst_out_vld", 64'(out_vld_o[1]), 64'h1);
    #2 reset = 1'b1;
    #1;
    check_idle("async_rst");
    check_val("async_rst_in_data",  in_data_o,  64'h0);
    check_val("async_rst_out_data", out_data_o, 64'h0);
`ifdef PAGE_BRIDGE_STATS_EN
    check_val("async_rst_stats", 64'(|stat_words), 64'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    in_ack_i  = '1;
    out_ack_i = '1;
    got = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_vld_o != '0 || out_vld_o != '0) got++;
    end
    check_val("no_stale_word", 64'(got), 64'd0);

`ifdef PAGE_BRIDGE_STATS_EN
    for (int i = 0; i < 16; i++) begin
      in_vld_i[1] = 1'b1;
      in_data_i[PB +: PB] = 32'hE0 + i;
      @(negedge clk);
    end
    in_vld_i[1] = 1'b0;
    @(negedge clk);
    check_val("stat_count16", 64'(stat_words[32 +: 32]), 64'd16);
    force dut.r_stat[1] = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.r_stat[1];
    for (int i = 0; i < 3; i++) begin
      in_vld_i[1] = 1'b1;
      in_data_i[PB +: PB] = 32'hF0 + i;
      @(negedge clk);
    end
    in_vld_i[1] = 1'b0;
    @(negedge clk);
    check_val("stat_saturate", 64'(stat_words[32 +: 32]), 64'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
